// File: rtl/sha3_theta_terms_if.sv
// Row-stream in / column-parity out bundle for the theta term producer.
// The slave side is the parity block; the master side feeds rows and consumes terms.
interface sha3_theta_terms_if;
    logic [4:0][63:0] irow;
    logic             ivalid;
    logic             ifirst;
    logic [4:0][63:0] oterm;
    logic             osample;
    logic             orestart;

    modport master (
        output irow,
        output ivalid,
        output ifirst,
        input  oterm,
        input  osample,
        input  orestart
    );

    modport slave (
        input  irow,
        input  ivalid,
        input  ifirst,
        output oterm,
        output osample,
        output orestart
    );
endinterface

// File: rtl/sha3_theta_terms.sv
// Keccak theta column-parity producer: folds five streamed rows into C[x]
// and strobes the result for the downstream theta element stage.
module sha3_theta_terms #(
    parameter int    OUTPUT_BUFFER = 1,
    parameter string STYLE         = "basic"
) (
    input  logic               clk,
    input  logic               rst,
    sha3_theta_terms_if.slave  bus
);

    if (STYLE != "basic") begin : g_bad_style
        $error("sha3_theta_terms: unsupported STYLE");
    end

    // Lane-wise fold; lane x only ever mixes with lane x, rotation happens downstream.
    function automatic logic [4:0][63:0] lane_xor(
        input logic [4:0][63:0] a,
        input logic [4:0][63:0] b
    );
        logic [4:0][63:0] r;
        for (int x = 0; x < 5; x++) begin
            r[x] = a[x] ^ b[x];
        end
        return r;
    endfunction

    logic [2:0]       cnt_q,     cnt_d;
    logic [4:0][63:0] acc_q,     acc_d;
    logic [4:0][63:0] term_q,    term_d;
    logic             sample_q,  sample_d;
    logic             restart_q, restart_d;

    logic [4:0][63:0] mix_s;
    logic             start_s;
    logic             complete_s;

    // Beat classification and the running parity candidate.
    always_comb begin
        mix_s      = lane_xor(acc_q, bus.irow);
        start_s    = bus.ivalid & ((cnt_q == 3'd0) | bus.ifirst);
        complete_s = bus.ivalid & (cnt_q == 3'd4) & ~bus.ifirst;
    end

    // Next-state for the row counter, accumulator and output registers.
    always_comb begin
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        term_d    = term_q;
        sample_d  = 1'b0;
        restart_d = 1'b0;
        if (!bus.ivalid) begin
            cnt_d = cnt_q;
        end else if (start_s) begin
            // ifirst on a partially filled block throws the partial away.
            acc_d     = bus.irow;
            cnt_d     = 3'd1;
            restart_d = (cnt_q != 3'd0);
        end else begin
            case (cnt_q)
                3'd1, 3'd2, 3'd3: begin
                    acc_d = mix_s;
                    cnt_d = cnt_q + 3'd1;
                end
                3'd4: begin
                    term_d   = mix_s;
                    sample_d = 1'b1;
                    cnt_d    = 3'd0;
                end
                default: begin
                    cnt_d = 3'd0;
                end
            endcase
        end
    end

    // State registers with synchronous reset taking priority over any beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= 3'd0;
            acc_q     <= '0;
            term_q    <= '0;
            sample_q  <= 1'b0;
            restart_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            term_q    <= term_d;
            sample_q  <= sample_d;
            restart_q <= restart_d;
        end
    end

    if (OUTPUT_BUFFER != 0) begin : g_out_reg
        assign bus.oterm    = term_q;
        assign bus.osample  = sample_q;
        assign bus.orestart = restart_q;
    end else begin : g_out_comb
        // Same-cycle path: oterm is only meaningful while osample is high.
        assign bus.oterm    = mix_s;
        assign bus.osample  = complete_s;
        assign bus.orestart = restart_q;
    end

endmodule

// File: tb/tb_sha3_theta_terms.sv
// Directed bench driving a buffered and an unbuffered instance with the same
// row stream; expected parities flow through scoreboard queues.
module tb_sha3_theta_terms;

    logic clk;
    logic rst;

    sha3_theta_terms_if bus1 ();
    sha3_theta_terms_if bus0 ();

    sha3_theta_terms #(.OUTPUT_BUFFER(1), .STYLE("basic")) u_dut_buf (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    sha3_theta_terms #(.OUTPUT_BUFFER(0), .STYLE("basic")) u_dut_comb (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nvec;
    int nerr;

    logic [319:0] q_buf[$];
    logic [319:0] q_comb[$];

    int               m_cnt;
    logic [4:0][63:0] m_acc;
    logic [4:0][63:0] last_term;

    task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0][63:0] rnd_row();
        logic [4:0][63:0] r;
        for (int x = 0; x < 5; x++) begin
            r[x] = {$urandom(), $urandom()};
        end
        return r;
    endfunction

    task automatic drive(input logic [4:0][63:0] row, input logic v, input logic f);
        bus1.irow = row;  bus1.ivalid = v;  bus1.ifirst = f;
        bus0.irow = row;  bus0.ivalid = v;  bus0.ifirst = f;
    endtask

    // One clock of stimulus; called #1 after a posedge, returns #1 after the next.
    task automatic step(input logic [4:0][63:0] row, input logic v, input logic f);
        logic             exp_comp;
        logic             exp_rst;
        logic [4:0][63:0] exp_par;
        logic [319:0]     got;
        drive(row, v, f);
        exp_comp = v && (m_cnt == 4) && !f;
        exp_rst  = v && f && (m_cnt != 0);
        for (int x = 0; x < 5; x++) exp_par[x] = m_acc[x] ^ row[x];
        #1;
        chk("comb_osample", bus0.osample, exp_comp);
        if (exp_comp) begin
            q_comb.push_back(exp_par);
            got = q_comb.pop_front();
            chk("comb_oterm", bus0.oterm, got);
        end
        if (v) begin
            if (m_cnt == 0 || f) begin
                m_acc = row;
                m_cnt = 1;
            end else if (m_cnt == 4) begin
                m_cnt = 0;
                q_buf.push_back(exp_par);
            end else begin
                for (int x = 0; x < 5; x++) m_acc[x] = m_acc[x] ^ row[x];
                m_cnt++;
            end
        end
        @(posedge clk);
        #1;
        chk("buf_osample", bus1.osample, exp_comp);
        chk("buf_orestart", bus1.orestart, exp_rst);
        chk("comb_orestart", bus0.orestart, exp_rst);
        if (exp_comp) begin
            if (q_buf.size() > 0) begin
                got = q_buf.pop_front();
                chk("buf_oterm", bus1.oterm, got);
                last_term = got;
            end else begin
                chk("buf_queue_empty", 1'b1, 1'b0);
            end
        end else begin
            chk("buf_oterm_hold", bus1.oterm, last_term);
        end
    endtask

    task automatic do_reset(input logic v);
        rst = 1'b1;
        drive(rnd_row(), v, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_cnt = 0;
        m_acc = '0;
        last_term = '0;
        chk("rst_oterm", bus1.oterm, 320'd0);
        chk("rst_osample", bus1.osample, 1'b0);
        chk("rst_orestart", bus1.orestart, 1'b0);
        chk("rst_comb_orestart", bus0.orestart, 1'b0);
    endtask

    logic [4:0][63:0] row;
    logic [4:0][63:0] ones;
    logic [63:0]      pat;
    logic [4:0][63:0] blk[5];

    initial begin
        nvec = 0;
        nerr = 0;
        rst = 1'b1;
        drive('0, 1'b0, 1'b0);
        m_cnt = 0;
        m_acc = '0;
        last_term = '0;
        ones = '1;
        @(posedge clk);
        #1;
        do_reset(1'b0);

        // Single-bit walk: lane x of row y carries bit 8y+x.
        for (int y = 0; y < 5; y++) begin
            for (int x = 0; x < 5; x++) row[x] = 64'h1 << (8 * y + x);
            step(row, 1'b1, (y == 0));
        end
        pat = 64'h0000_0001_0101_0101;
        for (int x = 0; x < 5; x++) chk("walk_lane", bus1.oterm[x], pat << x);
        step('0, 1'b0, 1'b0);

        // Odd and even counts of all-ones rows; second block starts implicitly.
        for (int y = 0; y < 5; y++) step(ones, 1'b1, (y == 0));
        chk("ones_odd", bus1.oterm, ones);
        for (int y = 0; y < 5; y++) step((y == 4) ? '0 : ones, 1'b1, 1'b0);
        chk("ones_even", bus1.oterm, 320'd0);

        // Idle gap of three cycles inside a block.
        for (int y = 0; y < 5; y++) blk[y] = rnd_row();
        for (int y = 0; y < 3; y++) step(blk[y], 1'b1, (y == 0));
        for (int g = 0; g < 3; g++) step(rnd_row(), 1'b0, 1'b1);
        for (int y = 3; y < 5; y++) step(blk[y], 1'b1, 1'b0);
        row = blk[0] ^ blk[1] ^ blk[2] ^ blk[3] ^ blk[4];
        chk("gap_parity", bus1.oterm, row);

        // Two blocks back to back with no dead cycle.
        for (int b = 0; b < 10; b++) step(rnd_row(), 1'b1, (b % 5 == 0));
        step('0, 1'b0, 1'b0);

        // Restart after three beats; only the new block may appear.
        for (int y = 0; y < 3; y++) step(rnd_row(), 1'b1, (y == 0));
        for (int y = 0; y < 5; y++) blk[y] = rnd_row();
        for (int y = 0; y < 5; y++) step(blk[y], 1'b1, (y == 0));
        row = blk[0] ^ blk[1] ^ blk[2] ^ blk[3] ^ blk[4];
        chk("restart_parity", bus1.oterm, row);

        // ifirst landing on the fifth slot restarts instead of completing.
        for (int y = 0; y < 4; y++) step(rnd_row(), 1'b1, (y == 0));
        for (int y = 0; y < 5; y++) step(rnd_row(), 1'b1, (y == 0));

        // Reset mid-block, then a clean block.
        for (int y = 0; y < 2; y++) step(rnd_row(), 1'b1, (y == 0));
        do_reset(1'b1);
        step('0, 1'b0, 1'b0);
        for (int y = 0; y < 5; y++) blk[y] = rnd_row();
        for (int y = 0; y < 5; y++) step(blk[y], 1'b1, (y == 0));
        row = blk[0] ^ blk[1] ^ blk[2] ^ blk[3] ^ blk[4];
        chk("post_rst_parity", bus1.oterm, row);
        step('0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
